// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell stepped LSB-first, borrow kept in a flop.
// diff/bout/zero are held from one completion to the next; start is honoured only in IDLE or DONE.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             x_s, y_s, d_s, nb_s;
  logic [WIDTH-1:0] sd_next_s;

  // Full-subtractor cell on the current LSBs plus the shifted-in result bit.
  always_comb begin
    x_s       = sa_q[0];
    y_s       = sb_q[0];
    d_s       = x_s ^ y_s ^ br_q;
    nb_s      = (~x_s & y_s) | (~(x_s ^ y_s) & br_q);
    sd_next_s = {d_s, sd_q[WIDTH-1:1]};
  end

  // Next-state, datapath and output decode; every register holds unless its state says otherwise.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sd_d  = sd_next_s;
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = nb_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_BIT) begin
          diff_d  = sd_next_s;
          bout_d  = nb_s;
          zero_d  = (sd_next_s == {WIDTH{1'b0}});
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy/done are flopped from the next state so the ports stay register-driven.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      sd_q    <= {WIDTH{1'b0}};
      br_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed and random ops at WIDTH=8, exhaustive at WIDTH=4,
// all compared against plain-arithmetic expectations (a - b - bin, unsigned borrow, zero).
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8, bin8, busy8, done8, bout8, zero8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4, zero4;
  logic [3:0] a4, b4, diff4;

  int checks;
  int errors;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic difference, borrow = negative result, zero on wrapped value.
  task automatic ref_sub(input int w, input longint ua, input longint ub, input longint ubin,
                         output longint ed, output logic eb, output logic ez);
    longint raw;
    raw = ua - ub - ubin;
    ed  = raw & ((longint'(1) << w) - 1);
    eb  = (raw < 0);
    ez  = (ed == 0);
  endtask

  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input bit inj);
    int lat, bcnt, extra, both;
    longint ed;
    logic eb, ez;
    @(negedge clk);
    start8 = 1'b1; a8 = ia; b8 = ib; bin8 = ibin;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0; both = 0;
    while (!done8 && lat < 20) begin
      if (busy8) bcnt++;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      start8 = (inj && lat == 3);
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    ref_sub(8, ia, ib, ibin, ed, eb, ez);
    chk("lat8", lat, 8);
    chk("busy_cycles8", bcnt, 8);
    chk("done8", done8, 1);
    chk("busy_at_done8", busy8, 0);
    chk("diff8", diff8, ed[7:0]);
    chk("bout8", bout8, eb);
    chk("zero8", zero8, ez);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
      if (busy8 && done8) both++;
    end
    chk("extra_done8", extra, 0);
    chk("busy_and_done8", both, 0);
    chk("diff_hold8", diff8, ed[7:0]);
  endtask

  task automatic b2b8(input int n);
    int lat;
    logic [7:0] qa, qb;
    logic qbin;
    longint ed;
    logic eb, ez;
    @(negedge clk);
    qa = 8'($urandom); qb = 8'($urandom); qbin = 1'($urandom);
    start8 = 1'b1; a8 = qa; b8 = qb; bin8 = qbin;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lat = 0;
      while (!done8 && lat < 20) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      ref_sub(8, qa, qb, qbin, ed, eb, ez);
      chk("b2b_period", lat + 1, 9);
      chk("b2b_diff", diff8, ed[7:0]);
      chk("b2b_bout", bout8, eb);
      chk("b2b_zero", zero8, ez);
      qa = 8'($urandom); qb = 8'($urandom); qbin = 1'($urandom);
      a8 = qa; b8 = qb; bin8 = qbin;
      if (i == n - 1) start8 = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin);
    int lat;
    longint ed;
    logic eb, ez;
    @(negedge clk);
    start4 = 1'b1; a4 = ia; b4 = ib; bin4 = ibin;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    ref_sub(4, ia, ib, ibin, ed, eb, ez);
    chk("lat4", lat, 4);
    chk("diff4", diff4, ed[3:0]);
    chk("bout4", bout4, eb);
    chk("zero4", zero4, ez);
  endtask

  initial begin
    int extra;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bout8, 0);
    chk("rst_zero", zero8, 0);
    rst_n = 1'b1;

    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op8(8'h80, 8'h7F, 1'b1, 1'b0);
    do_op8(8'h12, 8'h34, 1'b0, 1'b1);
    do_op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op8(8'h00, 8'h01, 1'b0, 1'b0);

    // Abort mid-run: results drop to zero at once and no done follows.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h15; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_diff", diff8, 0);
    chk("arst_bout", bout8, 0);
    chk("arst_zero", zero8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("no_done_after_rst", extra, 0);
    do_op8(8'hC3, 8'h15, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    b2b8(6);

    for (int ea = 0; ea < 16; ea++) begin
      for (int eb = 0; eb < 16; eb++) begin
        for (int ec = 0; ec < 2; ec++) begin
          run4(4'(ea), 4'(eb), 1'(ec));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
